// File: rtl/eth_smp_buf_writer_if.sv
// Sample-stream, buffer-RAM write and sender hand-off signals of eth_smp_buf_writer.
// master = the writer block, slave = the environment (sample source, RAM, UDP sender).
interface eth_smp_buf_writer_if #(
    parameter int ADDR_W = 10,
    parameter int SMP_W  = 16
);
    logic [SMP_W-1:0]   i_smp_data;
    logic               i_smp_vld;
    logic               o_smp_rdy;
    logic [ADDR_W-1:0]  o_wr_addr;
    logic [2*SMP_W-1:0] o_wr_data;
    logic               o_wr_en;
    logic               o_rd_bank;
    logic               o_frame_rdy;
    logic               i_rd_busy;
    logic [31:0]        o_frame_cnt;
    logic [15:0]        o_ovf_cnt;

    modport master (
        input  i_smp_data,
        input  i_smp_vld,
        output o_smp_rdy,
        output o_wr_addr,
        output o_wr_data,
        output o_wr_en,
        output o_rd_bank,
        output o_frame_rdy,
        input  i_rd_busy,
        output o_frame_cnt,
        output o_ovf_cnt
    );

    modport slave (
        output i_smp_data,
        output i_smp_vld,
        input  o_smp_rdy,
        input  o_wr_addr,
        input  o_wr_data,
        input  o_wr_en,
        input  o_rd_bank,
        input  o_frame_rdy,
        output i_rd_busy,
        input  o_frame_cnt,
        input  o_ovf_cnt
    );
endinterface

// File: rtl/eth_smp_buf_writer.sv
// Packs 16-bit sample pairs into a ping-pong 2x512x32 buffer, one bank per i_msync_n frame.
// Define BUF_HDR_EN to reserve word 0 of each bank for a {frame_cnt[15:0], 6'b0, word_cnt} header.
module eth_smp_buf_writer #(
    parameter int ADDR_W = 10,
    parameter int SMP_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_msync_n,
    eth_smp_buf_writer_if.master bus
);
    localparam int BANK_W = ADDR_W - 1;
    localparam int WORD_W = 2 * SMP_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'((1 << BANK_W) - 1);
`ifdef BUF_HDR_EN
    localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_PTR = '0;
`endif

    typedef enum logic [1:0] {IDLE, FILL, COMMIT, SWAP} state_t;

    state_t            state_q, state_d;
    logic              meta_q, meta_d;
    logic              sync_q, sync_d;
    logic              sync_dly_q, sync_dly_d;
    logic              sync_fall_q, sync_fall_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              half_q, half_d;
    logic [SMP_W-1:0]  lo_q, lo_d;
    logic              restart_q, restart_d;
    logic              wr_bank_q, wr_bank_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              rd_bank_q, rd_bank_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       ovf_cnt_q, ovf_cnt_d;
    logic              smp_rdy;

    // Two-stage synchronizer plus a registered falling-edge pulse (pin to pulse = 3 clk)
    always_comb begin
        meta_d      = i_msync_n;
        sync_d      = meta_q;
        sync_dly_d  = sync_q;
        sync_fall_d = sync_dly_q & ~sync_q;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        half_d      = half_q;
        lo_d        = lo_q;
        restart_d   = restart_q;
        wr_bank_d   = wr_bank_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_bank_d   = rd_bank_q;
        frame_rdy_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        smp_rdy     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sync_fall_q) begin
                    state_d = FILL;
                    ptr_d   = FIRST_PTR;
                    half_d  = 1'b0;
                end
            end

            FILL: begin
                // A sync edge wins over a coincident sample: the frame closes without it
                smp_rdy = ~sync_fall_q;
                if (sync_fall_q) begin
                    restart_d = 1'b1;
                    state_d   = COMMIT;
                end else if (bus.i_smp_vld) begin
                    if (!half_q) begin
                        lo_d   = bus.i_smp_data;
                        half_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {wr_bank_q, ptr_q[BANK_W-1:0]};
                        wr_data_d = {bus.i_smp_data, lo_q};
                        ptr_d     = ptr_q + 1'b1;
                        half_d    = 1'b0;
                        if (ptr_q == LAST_PTR) begin
                            state_d = COMMIT;
                        end
                    end
                end
            end

            COMMIT: begin
`ifdef BUF_HDR_EN
                // ptr already points past the last payload word, so ptr - first = words written
                wr_en_d                   = 1'b1;
                wr_addr_d                 = {wr_bank_q, {BANK_W{1'b0}}};
                wr_data_d                 = '0;
                wr_data_d[WORD_W-1 -: 16] = frame_cnt_q[15:0];
                wr_data_d[ADDR_W-1:0]     = ptr_q - FIRST_PTR;
`endif
                rd_bank_d   = wr_bank_q;
                frame_rdy_d = 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (sync_fall_q) begin
                    restart_d = 1'b1;
                end
                state_d = SWAP;
            end

            SWAP: begin
                // The other bank may still be on the wire; hold off until the sender lets go
                if (!bus.i_rd_busy) begin
                    wr_bank_d = ~wr_bank_q;
                    if (restart_q || sync_fall_q) begin
                        state_d   = FILL;
                        ptr_d     = FIRST_PTR;
                        half_d    = 1'b0;
                        restart_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (sync_fall_q) begin
                    restart_d = 1'b0;
                    if (ovf_cnt_q != 16'hFFFF) begin
                        ovf_cnt_d = ovf_cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            meta_q      <= 1'b1;
            sync_q      <= 1'b1;
            sync_dly_q  <= 1'b1;
            sync_fall_q <= 1'b0;
            ptr_q       <= '0;
            half_q      <= 1'b0;
            lo_q        <= '0;
            restart_q   <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_bank_q   <= 1'b1;
            frame_rdy_q <= 1'b0;
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            sync_dly_q  <= sync_dly_d;
            sync_fall_q <= sync_fall_d;
            ptr_q       <= ptr_d;
            half_q      <= half_d;
            lo_q        <= lo_d;
            restart_q   <= restart_d;
            wr_bank_q   <= wr_bank_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_bank_q   <= rd_bank_d;
            frame_rdy_q <= frame_rdy_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign bus.o_smp_rdy   = smp_rdy;
    assign bus.o_wr_en     = wr_en_q;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_rd_bank   = rd_bank_q;
    assign bus.o_frame_rdy = frame_rdy_q;
    assign bus.o_frame_cnt = frame_cnt_q;
    assign bus.o_ovf_cnt   = ovf_cnt_q;
endmodule
